// File: rtl/axis_mux_pkg.sv
// Shared types for the N:1 packet-locked AXI-Stream mux.
// The beat struct itself lives in the top because its field widths follow module parameters.
package axis_mux_pkg;

   typedef enum logic [1:0] {
      RST_HOLD = 2'd0,
      IDLE     = 2'd1,
      PKT      = 2'd2
   } mux_state_e;

   // Packed width of one buffered beat: {data, last, id}.
   function automatic int beat_width(input int dw, input int sw);
      return dw + 1 + sw;
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Output register plus one-entry skid register for the stream mux master side.
// room_o is registered, so upstream ready never depends combinationally on out_ready_i.
module axis_skid_buf #(
   parameter int BW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [BW-1:0] in_beat_i,
   input  logic          in_valid_i,
   output logic          room_o,
   output logic [BW-1:0] out_beat_o,
   output logic          out_valid_o,
   input  logic          out_ready_i
);

   logic [BW-1:0] out_q, out_d;
   logic [BW-1:0] skid_q, skid_d;
   logic          out_valid_q, out_valid_d;
   logic          room_q, room_d;

   // A stalled output parks an incoming beat in the skid slot; otherwise the skid drains first.
   always_comb begin
      out_d       = out_q;
      skid_d      = skid_q;
      out_valid_d = out_valid_q;
      room_d      = room_q;
      if (out_valid_q && !out_ready_i) begin
         if (in_valid_i) begin
            skid_d = in_beat_i;
            room_d = 1'b0;
         end
      end else if (!room_q) begin
         out_d       = skid_q;
         out_valid_d = 1'b1;
         room_d      = 1'b1;
      end else if (in_valid_i) begin
         out_d       = in_beat_i;
         out_valid_d = 1'b1;
      end else begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         room_q      <= 1'b1;
      end else begin
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         room_q      <= room_d;
      end
   end

   assign out_beat_o  = out_q;
   assign out_valid_o = out_valid_q;
   assign room_o      = room_q;

endmodule

// File: rtl/axis_pkt_mux_n_1.sv
// N:1 AXI-Stream mux with optional packet locking, registered output and channel-ID sideband.
// Holds channel selection, the lock FSM and the slave-side ready fan-out.
module axis_pkt_mux_n_1
   import axis_mux_pkg::*;
#(
   parameter  int NS       = 4,
   parameter  int DW       = 8,
   parameter  bit LOCK_PKT = 1'b1,
   localparam int SW       = (NS > 1) ? $clog2(NS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SW-1:0]    sel,
   input  logic [NS*DW-1:0] s_tdata,
   input  logic [NS-1:0]    s_tvalid,
   input  logic [NS-1:0]    s_tlast,
   output logic [NS-1:0]    s_tready,
   output logic [DW-1:0]    m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   output logic [SW-1:0]    m_tid,
   input  logic             m_tready
);

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [SW-1:0] id;
   } beat_t;

   localparam int BW = beat_width(DW, SW);

   mux_state_e    state_q, state_d;
   logic [SW-1:0] cur_ch_q, cur_ch_d;
   logic          room;
   logic          accept;
   logic          sel_ok;
   logic          load_sel;
   beat_t         in_beat;
   beat_t         out_beat;

   assign sel_ok = (32'(sel) < 32'(NS));
   assign accept = |(s_tready & s_tvalid);

   // Only the current channel may see ready, and never during the post-reset hold cycle.
   always_comb begin
      s_tready = '0;
      in_beat  = '0;
      for (int i = 0; i < NS; i++) begin
         if (cur_ch_q == SW'(i)) begin
            s_tready[i]  = room && (state_q != RST_HOLD);
            in_beat.data = s_tdata[i*DW +: DW];
            in_beat.last = s_tlast[i];
         end
      end
      in_beat.id = cur_ch_q;
   end

   // The first non-last beat of a packet freezes the channel until its tlast beat is taken.
   always_comb begin
      state_d  = state_q;
      cur_ch_d = cur_ch_q;
      load_sel = 1'b0;
      unique case (state_q)
         RST_HOLD: begin
            state_d  = IDLE;
            load_sel = 1'b1;
         end
         IDLE: begin
            load_sel = !(accept && !in_beat.last);
            if (LOCK_PKT && accept && !in_beat.last) begin
               state_d = PKT;
            end
         end
         PKT: begin
            load_sel = accept && in_beat.last;
            if (accept && in_beat.last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!LOCK_PKT) begin
         load_sel = 1'b1;
      end
      if (load_sel && sel_ok) begin
         cur_ch_d = sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RST_HOLD;
         cur_ch_q <= '0;
      end else begin
         state_q  <= state_d;
         cur_ch_q <= cur_ch_d;
      end
   end

   axis_skid_buf #(
      .BW (BW)
   ) u_skid (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_beat_i   (in_beat),
      .in_valid_i  (accept),
      .room_o      (room),
      .out_beat_o  (out_beat),
      .out_valid_o (m_tvalid),
      .out_ready_i (m_tready)
   );

   assign m_tdata = out_beat.data;
   assign m_tlast = out_beat.last;
   assign m_tid   = out_beat.id;

endmodule

// File: tb/tb_axis_pkt_mux_n_1.sv
// Bench for axis_pkt_mux_n_1: a packet-locked and a per-beat instance share one stimulus stream.
// Directed table rows carry hand-derived expectations; a depth-2 queue model checks every cycle.
module tb_axis_pkt_mux_n_1;

   localparam int NSB = 5;

   typedef struct {
      bit          chk;
      bit          rst;
      logic [2:0]  sel;
      logic [4:0]  valid;
      logic [4:0]  last;
      logic [39:0] data;
      bit          mr;
      logic [4:0]  eRdy;
      bit          eVal;
      logic [7:0]  eData;
      bit          eLast;
      logic [2:0]  eId;
      bit          dChk;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sel;
   logic [39:0] sTdata;
   logic [4:0]  sTvalid;
   logic [4:0]  sTlast;
   logic        mTready;

   logic [4:0]  aTready, bTready;
   logic [7:0]  aTdata, bTdata;
   logic        aTvalid, bTvalid, aTlast, bTlast;
   logic [2:0]  aTid, bTid;

   int vecs  = 0;
   int fails = 0;

   int         curM[2];
   bit         lockedM[2];
   bit         holdM[2];
   int         occM[2];
   logic [7:0] qData[2][2];
   bit         qLast[2][2];
   int         qId[2][2];

   vec_t tbl[34];

   always #5 clk = ~clk;

   axis_pkt_mux_n_1 #(.NS(NSB), .DW(8), .LOCK_PKT(1'b1)) dutA (
      .clk(clk), .rst(rst), .sel(sel), .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tlast(sTlast),
      .s_tready(aTready), .m_tdata(aTdata), .m_tvalid(aTvalid), .m_tlast(aTlast), .m_tid(aTid),
      .m_tready(mTready)
   );

   axis_pkt_mux_n_1 #(.NS(NSB), .DW(8), .LOCK_PKT(1'b0)) dutB (
      .clk(clk), .rst(rst), .sel(sel), .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tlast(sTlast),
      .s_tready(bTready), .m_tdata(bTdata), .m_tvalid(bTvalid), .m_tlast(bTlast), .m_tid(bTid),
      .m_tready(mTready)
   );

   function automatic vec_t mk(bit r, int s, logic [4:0] v, logic [4:0] l, logic [39:0] d, bit mr,
                               logic [4:0] er, bit ev, logic [7:0] ed, bit el, int eid, bit dc);
      vec_t t;
      t.chk = 1'b1; t.rst = r; t.sel = 3'(s); t.valid = v; t.last = l; t.data = d; t.mr = mr;
      t.eRdy = er; t.eVal = ev; t.eData = ed; t.eLast = el; t.eId = 3'(eid); t.dChk = dc;
      return t;
   endfunction

   function automatic logic [39:0] onCh(int ch, logic [7:0] b);
      return 40'(b) << (ch * 8);
   endfunction

   function automatic logic [4:0] expReady(int i);
      if (holdM[i] || occM[i] >= 2) return 5'b0;
      return 5'(1 << curM[i]);
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      vecs++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   task automatic checkOutput(input int i, input logic [4:0] rdy, input logic v, input logic [7:0] d,
                              input logic l, input logic [2:0] id);
      string tag;
      tag = (i == 0) ? "lock" : "beat";
      cmp($sformatf("%s s_tready", tag), 32'(rdy), 32'(expReady(i)));
      cmp($sformatf("%s m_tvalid", tag), 32'(v), 32'(occM[i] > 0));
      if (occM[i] > 0) begin
         cmp($sformatf("%s m_tdata", tag), 32'(d), 32'(qData[i][0]));
         cmp($sformatf("%s m_tlast", tag), 32'(l), 32'(qLast[i][0]));
         cmp($sformatf("%s m_tid", tag), 32'(id), 32'(qId[i][0]));
      end
   endtask

   // Reference: a two-deep queue of held beats plus the current channel and a packet-open flag.
   task automatic modelAdvance(input int i, input bit lockMode);
      bit         acc;
      bit         allow;
      int         c;
      logic [7:0] bd;
      bit         bl;
      if (rst) begin
         occM[i] = 0; curM[i] = 0; lockedM[i] = 1'b0; holdM[i] = 1'b1;
         return;
      end
      c   = curM[i];
      acc = !holdM[i] && (occM[i] < 2) && sTvalid[c];
      bd  = sTdata[c*8 +: 8];
      bl  = sTlast[c];
      if (occM[i] > 0 && mTready) begin
         qData[i][0] = qData[i][1]; qLast[i][0] = qLast[i][1]; qId[i][0] = qId[i][1];
         occM[i]--;
      end
      if (acc) begin
         qData[i][occM[i]] = bd; qLast[i][occM[i]] = bl; qId[i][occM[i]] = c;
         occM[i]++;
      end
      if (holdM[i] || !lockMode) allow = 1'b1;
      else if (lockedM[i])       allow = acc && bl;
      else                       allow = !(acc && !bl);
      if (lockMode && acc) lockedM[i] = !bl;
      if (allow && int'(sel) < NSB) curM[i] = int'(sel);
      holdM[i] = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input bit tableChk, input int row);
      rst = v.rst; sel = v.sel; sTvalid = v.valid; sTlast = v.last; sTdata = v.data; mTready = v.mr;
      @(negedge clk);
      if (v.chk) begin
         checkOutput(0, aTready, aTvalid, aTdata, aTlast, aTid);
         checkOutput(1, bTready, bTvalid, bTdata, bTlast, bTid);
         if (tableChk) begin
            cmp($sformatf("row%0d s_tready", row), 32'(aTready), 32'(v.eRdy));
            cmp($sformatf("row%0d m_tvalid", row), 32'(aTvalid), 32'(v.eVal));
            if (v.dChk) begin
               cmp($sformatf("row%0d m_tdata", row), 32'(aTdata), 32'(v.eData));
               cmp($sformatf("row%0d m_tlast", row), 32'(aTlast), 32'(v.eLast));
               cmp($sformatf("row%0d m_tid", row), 32'(aTid), 32'(v.eId));
            end
         end
      end
      @(posedge clk);
      modelAdvance(0, 1'b1);
      modelAdvance(1, 1'b0);
      #1;
   endtask

   initial begin
      logic [39:0] g;
      vec_t        rv;
      g = {8'h00, 8'h13, 8'h12, 8'h11, 8'h10};

      tbl[0]  = mk(1, 2, 5'b00000, 5'b00000, 40'h0, 1, 5'b00000, 0, 8'h00, 0, 0, 0);
      tbl[0].chk = 1'b0;
      tbl[1]  = mk(0, 2, 5'b00000, 5'b00000, 40'h0, 1, 5'b00000, 0, 8'h00, 0, 0, 1);
      tbl[2]  = mk(0, 2, 5'b00000, 5'b00000, 40'h0, 1, 5'b00100, 0, 8'h00, 0, 0, 0);
      tbl[3]  = mk(0, 2, 5'b00100, 5'b00000, onCh(2, 8'hA0), 1, 5'b00100, 0, 8'h00, 0, 0, 0);
      tbl[4]  = mk(0, 1, 5'b00110, 5'b00010, onCh(2, 8'hA1) | onCh(1, 8'hB0), 1, 5'b00100, 1, 8'hA0, 0, 2, 1);
      tbl[5]  = mk(0, 1, 5'b00110, 5'b00110, onCh(2, 8'hA2) | onCh(1, 8'hB0), 1, 5'b00100, 1, 8'hA1, 0, 2, 1);
      tbl[6]  = mk(0, 1, 5'b00010, 5'b00010, onCh(1, 8'hB0), 1, 5'b00010, 1, 8'hA2, 1, 2, 1);
      tbl[7]  = mk(0, 1, 5'b00000, 5'b00000, 40'h0, 1, 5'b00010, 1, 8'hB0, 1, 1, 1);
      tbl[8]  = mk(0, 1, 5'b00000, 5'b00000, 40'h0, 1, 5'b00010, 0, 8'h00, 0, 0, 0);
      tbl[9]  = mk(0, 0, 5'b00000, 5'b00000, 40'h0, 1, 5'b00010, 0, 8'h00, 0, 0, 0);
      tbl[10] = mk(0, 0, 5'b00001, 5'b00000, onCh(0, 8'hC0), 1, 5'b00001, 0, 8'h00, 0, 0, 0);
      tbl[11] = mk(0, 0, 5'b00001, 5'b00000, onCh(0, 8'hC1), 0, 5'b00001, 1, 8'hC0, 0, 0, 1);
      tbl[12] = mk(0, 0, 5'b00001, 5'b00001, onCh(0, 8'hC2), 0, 5'b00000, 1, 8'hC0, 0, 0, 1);
      tbl[13] = mk(0, 0, 5'b00001, 5'b00001, onCh(0, 8'hC2), 1, 5'b00000, 1, 8'hC0, 0, 0, 1);
      tbl[14] = mk(0, 0, 5'b00001, 5'b00001, onCh(0, 8'hC2), 1, 5'b00001, 1, 8'hC1, 0, 0, 1);
      tbl[15] = mk(0, 0, 5'b00000, 5'b00000, 40'h0, 1, 5'b00001, 1, 8'hC2, 1, 0, 1);
      tbl[16] = mk(0, 0, 5'b00000, 5'b00000, 40'h0, 1, 5'b00001, 0, 8'h00, 0, 0, 0);
      tbl[17] = mk(0, 3, 5'b00000, 5'b00000, 40'h0, 1, 5'b00001, 0, 8'h00, 0, 0, 0);
      tbl[18] = mk(0, 5, 5'b01000, 5'b01000, onCh(3, 8'hD0), 1, 5'b01000, 0, 8'h00, 0, 0, 0);
      tbl[19] = mk(0, 5, 5'b01000, 5'b01000, onCh(3, 8'hD1), 1, 5'b01000, 1, 8'hD0, 1, 3, 1);
      tbl[20] = mk(0, 5, 5'b00000, 5'b00000, 40'h0, 1, 5'b01000, 1, 8'hD1, 1, 3, 1);
      tbl[21] = mk(0, 1, 5'b00000, 5'b00000, 40'h0, 1, 5'b01000, 0, 8'h00, 0, 0, 0);
      tbl[22] = mk(0, 1, 5'b00010, 5'b00000, onCh(1, 8'hE0), 1, 5'b00010, 0, 8'h00, 0, 0, 0);
      tbl[23] = mk(0, 1, 5'b00010, 5'b00000, onCh(1, 8'hE1), 1, 5'b00010, 1, 8'hE0, 0, 1, 1);
      tbl[24] = mk(1, 1, 5'b00010, 5'b00000, onCh(1, 8'hE2), 1, 5'b00010, 1, 8'hE1, 0, 1, 1);
      tbl[25] = mk(0, 1, 5'b00010, 5'b00000, onCh(1, 8'hE2), 1, 5'b00000, 0, 8'h00, 0, 0, 1);
      tbl[26] = mk(0, 1, 5'b00010, 5'b00010, onCh(1, 8'hF0), 1, 5'b00010, 0, 8'h00, 0, 0, 0);
      tbl[27] = mk(0, 0, 5'b00000, 5'b00000, 40'h0, 1, 5'b00010, 1, 8'hF0, 1, 1, 1);
      tbl[28] = mk(0, 1, 5'b01111, 5'b01111, g, 1, 5'b00001, 0, 8'h00, 0, 0, 0);
      tbl[29] = mk(0, 2, 5'b01110, 5'b01110, g, 1, 5'b00010, 1, 8'h10, 1, 0, 1);
      tbl[30] = mk(0, 3, 5'b01100, 5'b01100, g, 1, 5'b00100, 1, 8'h11, 1, 1, 1);
      tbl[31] = mk(0, 3, 5'b01000, 5'b01000, g, 1, 5'b01000, 1, 8'h12, 1, 2, 1);
      tbl[32] = mk(0, 3, 5'b00000, 5'b00000, 40'h0, 1, 5'b01000, 1, 8'h13, 1, 3, 1);
      tbl[33] = mk(0, 3, 5'b00000, 5'b00000, 40'h0, 1, 5'b01000, 0, 8'h00, 0, 0, 0);

      for (int r = 0; r < 34; r++) begin
         applyStimulus(tbl[r], 1'b1, r);
      end

      // Random traffic: illegal sel values, stalls, short packets and occasional mid-stream resets.
      for (int n = 0; n < 3000; n++) begin
         rv = mk(0, 0, 5'b0, 5'b0, 40'h0, 1, 5'b0, 0, 8'h00, 0, 0, 0);
         rv.rst = ($urandom_range(0, 63) == 0);
         rv.sel = 3'($urandom_range(0, 7));
         for (int c = 0; c < NSB; c++) begin
            rv.valid[c]        = ($urandom_range(0, 3) != 0);
            rv.last[c]         = ($urandom_range(0, 3) == 0);
            rv.data[c*8 +: 8]  = 8'($urandom_range(0, 255));
         end
         rv.mr = ($urandom_range(0, 3) != 0);
         applyStimulus(rv, 1'b0, n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
